// File: rtl/mod_counter_pkg.sv
// Shared types and sizing helpers for the programmable modulo counter.
package mod_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Smallest r with 2**r >= n; never returns less than 1 so widths stay legal.
    function automatic int ceil_log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/mod_counter_ctrl.sv
// Control FSM gating the modulo counter; busy/done are registered copies of the next state.
//   state | meaning
//   IDLE  | not counting, count holds
//   RUN   | counting on enable
//   HALT  | one-shot reached terminal, count holds until start or stop
module mod_counter_ctrl
    import mod_counter_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   start,
    input  logic   stop,
    input  logic   load,
    input  logic   term_event,
    input  logic   one_shot_q,
    output state_t state,
    output logic   busy,
    output logic   done
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
        end else if (load) begin
            // A load without start leaves the state alone, even if stop is also high.
            state <= state;
        end else if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (term_event && one_shot_q) begin
            state <= HALT;
            busy  <= 1'b0;
            done  <= 1'b1;
        end
    end

endmodule

// File: rtl/mod_counter_prog.sv
// Programmable-modulus up/down counter with load, one-shot mode and cascading tc pulse.
module mod_counter_prog
    import mod_counter_pkg::*;
#(
    parameter  int MAX_MODULUS       = 16,
    localparam int NBITS_FOR_COUNTER = ceil_log2(MAX_MODULUS),
    localparam int NBITS_FOR_MODULUS = ceil_log2(MAX_MODULUS + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         up_down,
    input  logic                         one_shot,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         load,
    input  logic [NBITS_FOR_COUNTER-1:0] load_value,
    input  logic [NBITS_FOR_MODULUS-1:0] modulus,
    output logic [NBITS_FOR_COUNTER-1:0] count,
    output logic                         terminal,
    output logic                         tc_pulse,
    output logic                         busy,
    output logic                         done
);

    localparam int NC = NBITS_FOR_COUNTER;
    localparam int NM = NBITS_FOR_MODULUS;
    localparam logic [NM-1:0] MAX_M = NM'(MAX_MODULUS);

    state_t         state;
    logic [NM-1:0]  mod_q;
    logic [NM-1:0]  mod_new;
    logic           one_shot_q;
    logic [NC-1:0]  last_q;
    logic [NC-1:0]  last_new;
    logic [NC-1:0]  load_clamped;
    logic           term_event;

    always_comb begin
        mod_new = modulus;
        if (modulus == '0) begin
            mod_new = NM'(1);
        end else if (modulus > MAX_M) begin
            mod_new = MAX_M;
        end
    end

    assign last_q       = NC'(mod_q - NM'(1));
    assign last_new     = NC'(mod_new - NM'(1));
    assign load_clamped = (load_value > last_new) ? last_new : load_value;

    assign terminal   = (count == ((up_down == DIR_DOWN) ? '0 : last_q));
    assign term_event = (state == RUN) && enable && terminal && !load && !start && !stop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count      <= '0;
            mod_q      <= MAX_M;
            one_shot_q <= 1'b0;
            tc_pulse   <= 1'b0;
        end else begin
            tc_pulse <= term_event;
            if (load) begin
                mod_q <= mod_new;
                count <= load_clamped;
                if (start) one_shot_q <= one_shot;
            end else if (start) begin
                mod_q      <= mod_new;
                one_shot_q <= one_shot;
                count      <= (up_down == DIR_UP) ? '0 : last_new;
            end else if ((state == RUN) && enable && !stop) begin
                if (terminal) begin
                    // One-shot holds at terminal; the FSM moves to HALT on the same edge.
                    if (!one_shot_q) count <= (up_down == DIR_UP) ? '0 : last_q;
                end else begin
                    count <= (up_down == DIR_UP) ? count + NC'(1) : count - NC'(1);
                end
            end
        end
    end

    mod_counter_ctrl u_ctrl (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .load       (load),
        .term_event (term_event),
        .one_shot_q (one_shot_q),
        .state      (state),
        .busy       (busy),
        .done       (done)
    );

endmodule
